fetch_queue: RTL
================

# fetch_queue

Instruction fetch queue that sits between the frontend and decode. It accepts up to INSTR_PER_FETCH fetch_entry_t slots per cycle from the frontend and compacts them, dropping invalid slots and slots behind a taken prediction or a faulting fetch. It presents one entry per cycle, in program order, to the decode stage. It is the consumer end of the frontend fetch interface and the producer end of the decode interface.

## Interface
Parameters:
- DEPTH, default IFQ_DEPTH (8): storage entries; must be a power of two and at least NR_IN.
- NR_IN, default INSTR_PER_FETCH (2): fetch slots offered per cycle.

Ports:
- clk_i  input  1  clock; all state is updated on the rising edge.
- rst_ni  input  1  reset; asynchronous and active-low.
- flush_i  input  1  discard all stored entries. Takes priority over push and pop in the same cycle.
- fetch_valid_i  input  1  the frontend offers a fetch group.
- fetch_entry_i  input  NR_IN x fetch_entry_t  fetch group; slot 0 is the oldest.
- fetch_ready_o  output  1  the queue accepts the group this cycle.
- decode_valid_o  output  1  decode_entry_o holds a valid entry.
- decode_entry_o  output  fetch_entry_t  oldest entry; its valid field equals decode_valid_o.
- decode_ack_i  input  1  decode consumes the entry. Legal only while decode_valid_o is high; ignored otherwise.

## Operation
- Storage: circular buffer with read pointer, write pointer (both $clog2(DEPTH) bits, wrapping modulo DEPTH) and count ($clog2(DEPTH+1) bits).
- fetch_ready_o = (DEPTH - count >= NR_IN) and not flush_i. It does not depend on decode_ack_i, so there is no combinational path from ack to ready.
- Push happens when fetch_valid_i and fetch_ready_o are both high.
- Slot filtering, scanning from slot 0 upward: a slot is kept if its valid bit is 1 and no earlier kept slot has predict.is_taken=1 or ex.valid=1. Kept slots are written at consecutive addresses starting at the write pointer. The write pointer advances by the number of kept slots, which may be 0.
- Pop happens when decode_ack_i is high and decode_valid_o is high. The read pointer advances by 1.
- Count update: count_next = count + kept - popped. Push and pop in the same cycle are both honoured.
- Flush: read pointer, write pointer and count go to 0. Any push or pop in that cycle is discarded.
- Entry contents (addr, instr, ex, predict) pass through unmodified.
- Reset: pointers and count are 0. fetch_ready_o=1, decode_valid_o=0, decode_entry_o all zero.

## Timing
- Without bypass: an entry pushed in cycle N appears on decode_valid_o in cycle N+1 at the earliest (registered storage, first-word-fall-through read).
- Full: when DEPTH - count < NR_IN, fetch_ready_o=0 even if the group would keep fewer than NR_IN slots. Ready rises in the cycle after a pop that frees enough room.
- Empty: decode_valid_o=0, and decode_ack_i has no effect.
- Wrap-around: writes that straddle index DEPTH-1 continue at index 0 with no bubble.
- Reset asserted mid-operation clears state immediately (asynchronously). The outputs are the reset values while rst_ni is low.
- Flush: decode_valid_o=0 in the cycle after flush_i. A new push is accepted in the cycle after flush.

## Configuration
- CONFIG_IFQ_BYPASS_EN, defined in sysconfig.svh.
- Defined: when count=0 and a push keeps at least one slot, the first kept slot drives decode_entry_o and decode_valid_o=1 in the same cycle.
  - If decode_ack_i is also high, that slot is not stored; only the remaining kept slots are written.
  - This adds a combinational path from fetch_entry_i to the decode port.
- Undefined: there is no bypass, and the minimum latency is 1 cycle as described in Timing.

## Structure
- In tortoise_pkg: fetch_entry_t, exception_t, sbe_predict_t, IFQ_DEPTH, INSTR_PER_FETCH (all existing).
- New in tortoise_pkg: typedef ifq_cnt_t = logic [$clog2(IFQ_DEPTH+1)-1:0].
- Sub-module fetch_compact: purely combinational. It produces a per-slot keep mask and the kept count from fetch_entry_i. Instantiate it once.

## Test plan
- Reset then idle: fetch_ready_o=1, decode_valid_o=0, count=0. Push 2 valid slots at PC 0x1000 and 0x1004 with no ack: decode presents 0x1000 from cycle N+1. Ack twice: 0x1000 then 0x1004, then empty.
- Taken branch in slot 0 (0x2000, is_taken=1), slot 1 at 0x2004 valid: only 0x2000 is stored and count becomes 1. The same applies for slot 0 with ex.valid=1 and cause set; the entry passes to decode with ex unchanged.
- Fill DEPTH=8 with 4 groups of 2, no ack: fetch_ready_o=0 at count=8 and also at count=7. After one ack, count=7 and ready stays 0. After two acks, ready=1.
- Wrap: keep push and ack active continuously for 20 cycles. Output PCs are strictly sequential with no drops or duplicates across the index 7→0 boundary.
- Simultaneous events: flush_i together with push and ack at count=5 gives count=0 and decode_valid_o=0 in the next cycle. Assert rst_ni low mid-stream: outputs immediately show the reset values.
- With CONFIG_IFQ_BYPASS_EN and an empty queue: push 0x3000/0x3004 with ack high. 0x3000 is visible and consumed in the same cycle, and count becomes 1 holding 0x3004.

Source files
------------

// File: rtl/tortoise_pkg.sv
// rtl/tortoise_pkg.sv - shared frontend/decode types and queue sizing
package tortoise_pkg;

   localparam int unsigned IFQ_DEPTH       = 8;
   localparam int unsigned INSTR_PER_FETCH = 2;

   typedef struct packed {
      logic [31:0] cause;
      logic [31:0] tval;
      logic        valid;
   } exception_t;

   typedef struct packed {
      logic [31:0] predict_address;
      logic        is_taken;
   } sbe_predict_t;

   typedef struct packed {
      logic [31:0]  addr;
      logic [31:0]  instr;
      exception_t   ex;
      sbe_predict_t predict;
      logic         valid;
   } fetch_entry_t;

   typedef logic [$clog2(IFQ_DEPTH+1)-1:0] ifq_cnt_t;

endpackage

// File: rtl/fetch_compact.sv
// rtl/fetch_compact.sv - per-slot keep mask and kept count for one fetch group
module fetch_compact
   import tortoise_pkg::*;
#(
   parameter int unsigned NR_IN = INSTR_PER_FETCH,
   parameter int unsigned CNT_W = $clog2(NR_IN+1)
) (
   input  fetch_entry_t       fetch_entry_i [NR_IN],
   output logic [NR_IN-1:0]   keep_o,
   output logic [CNT_W-1:0]   kept_cnt_o
);

   logic stop;
   logic unused_bits;

   // A kept taken branch or faulting slot ends the group; later slots are dead.
   always_comb begin
      stop       = 1'b0;
      keep_o     = '0;
      kept_cnt_o = '0;
      for (int i = 0; i < NR_IN; i++) begin
         if (fetch_entry_i[i].valid && !stop) begin
            keep_o[i]  = 1'b1;
            kept_cnt_o = kept_cnt_o + CNT_W'(1);
            stop       = fetch_entry_i[i].predict.is_taken || fetch_entry_i[i].ex.valid;
         end
      end
   end

   always_comb begin
      unused_bits = 1'b0;
      for (int i = 0; i < NR_IN; i++) begin
         unused_bits = unused_bits ^ (^fetch_entry_i[i]);
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - compacting fetch queue, frontend to decode; CONFIG_IFQ_BYPASS_EN enables empty-queue bypass
module fetch_queue
   import tortoise_pkg::*;
#(
   parameter int unsigned DEPTH = IFQ_DEPTH,
   parameter int unsigned NR_IN = INSTR_PER_FETCH
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         flush_i,
   input  logic         fetch_valid_i,
   input  fetch_entry_t fetch_entry_i [NR_IN],
   output logic         fetch_ready_o,
   output logic         decode_valid_o,
   output fetch_entry_t decode_entry_o,
   input  logic         decode_ack_i
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

`ifdef CONFIG_IFQ_BYPASS_EN
   localparam bit BYPASS_EN = 1'b1;
`else
   localparam bit BYPASS_EN = 1'b0;
`endif

   fetch_entry_t       mem_q [DEPTH];
   logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0]   cnt_q;

   logic [NR_IN-1:0]   keep;
   logic [CNT_W-1:0]   kept_cnt;
   logic               push, pop, empty, bypass, skip;
   fetch_entry_t       first_kept, head;
   logic [NR_IN-1:0]   wr_en;
   logic [PTR_W-1:0]   wr_addr [NR_IN];
   logic [CNT_W-1:0]   run;

   fetch_compact #(
      .NR_IN (NR_IN),
      .CNT_W (CNT_W)
   ) u_compact (
      .fetch_entry_i (fetch_entry_i),
      .keep_o        (keep),
      .kept_cnt_o    (kept_cnt)
   );

   // Ready looks only at occupancy so decode_ack_i never reaches fetch_ready_o.
   assign empty          = (cnt_q == '0);
   assign fetch_ready_o  = ((CNT_W'(DEPTH) - cnt_q) >= CNT_W'(NR_IN)) && !flush_i;
   assign push           = fetch_valid_i && fetch_ready_o;
   assign bypass         = BYPASS_EN && empty && push && (kept_cnt != '0);
   assign decode_valid_o = !empty || bypass;
   assign pop            = decode_ack_i && decode_valid_o;
   assign skip           = bypass && decode_ack_i;

   always_comb begin
      first_kept = '0;
      for (int i = NR_IN - 1; i >= 0; i--) begin
         if (keep[i]) first_kept = fetch_entry_i[i];
      end
   end

   always_comb begin
      head = bypass ? first_kept : mem_q[rd_ptr_q];
      if (!decode_valid_o) head = '0;
      head.valid = decode_valid_o;
   end

   assign decode_entry_o = head;

   // Kept slots pack at consecutive addresses; a bypass-consumed first slot is never stored.
   always_comb begin
      run   = '0;
      wr_en = '0;
      for (int i = 0; i < NR_IN; i++) begin
         wr_addr[i] = wr_ptr_q + PTR_W'(run - CNT_W'(skip));
         wr_en[i]   = push && keep[i] && !(skip && (run == '0));
         if (keep[i]) run = run + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NR_IN; i++) begin
         if (wr_en[i]) mem_q[wr_addr[i]] <= fetch_entry_i[i];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else if (flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(kept_cnt - CNT_W'(skip));
         if (pop && !skip) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         cnt_q <= cnt_q + (push ? kept_cnt : '0) - CNT_W'(pop);
      end
   end

endmodule
